scan_dff_bank: RTL and testbench

SCAN_DFF_BANK -- requirements
Module: scan_dff_bank

---
 rtl/scan_dff_bank.sv | 103 ++++++++++
 tb/tb_scan_dff_bank.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/scan_dff_bank.sv
// Scan-capable D flip-flop bank: parallel load, serial scan shift with frame
// counting, and an optional shadow output register (define SCAN_SHADOW_EN).
module scan_dff_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      SHIFT_DIR = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  input  logic             DE,
  input  logic             SCD,
  input  logic             SCE,
  input  logic             UPD,
  output logic [WIDTH-1:0] Q,
  output logic             SCO,
  output logic             SCAN_DONE
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_d;
  logic [WIDTH-1:0] shift_val;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             done_q;
  logic             done_d;

  // Shift path and serial output; the scan-out bit is the one about to leave.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shift_val = SCD;
      assign SCO       = core_q[0];
    end else if (SHIFT_DIR == 0) begin : g_msb
      assign shift_val = {core_q[WIDTH-2:0], SCD};
      assign SCO       = core_q[WIDTH-1];
    end else begin : g_lsb
      assign shift_val = {SCD, core_q[WIDTH-1:1]};
      assign SCO       = core_q[0];
    end
  endgenerate

  // Core next-state and frame counter; any edge without SCE aborts the frame.
  always_comb begin
    core_d = core_q;
    cnt_d  = '0;
    done_d = 1'b0;
    if (SCE) begin
      core_d = shift_val;
      if (cnt_q == CNT_LAST) begin
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (DE) begin
      core_d = D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      core_q <= RESET_VAL;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      core_q <= core_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign SCAN_DONE = done_q;

`ifdef SCAN_SHADOW_EN
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;

  // Shadow samples the pre-edge core, so a same-edge load is not visible yet.
  always_comb begin
    shadow_d = shadow_q;
    if (UPD && !SCE) begin
      shadow_d = core_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadow_q <= RESET_VAL;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign Q = shadow_q;
`else
  logic upd_unused;
  assign upd_unused = UPD;
  assign Q          = core_q;
`endif

endmodule

// File: tb/tb_scan_dff_bank.sv
// Directed bench for scan_dff_bank: one MSB-shifting and one LSB-shifting bank
// driven in parallel; expectations follow SCAN_SHADOW_EN when defined.
module tb_scan_dff_bank;

  logic       CLK;
  logic       RESET;
  logic [7:0] D;
  logic       DE;
  logic       SCD;
  logic       SCE;
  logic       UPD;
  logic [7:0] q0;
  logic [7:0] q1;
  logic       sco0;
  logic       sco1;
  logic       done0;
  logic       done1;

  int checks = 0;
  int errors = 0;

  scan_dff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SHIFT_DIR(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .D(D), .DE(DE), .SCD(SCD), .SCE(SCE), .UPD(UPD),
    .Q(q0), .SCO(sco0), .SCAN_DONE(done0)
  );

  scan_dff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .SHIFT_DIR(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .D(D), .DE(DE), .SCD(SCD), .SCE(SCE), .UPD(UPD),
    .Q(q1), .SCO(sco1), .SCAN_DONE(done1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic rst, input logic sce, input logic de,
                       input logic upd, input logic scd, input logic [7:0] d);
    RESET = rst; SCE = sce; DE = de; UPD = upd; SCD = scd; D = d;
  endtask

  bit scd_v [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
  bit sco_v [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  initial begin
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);

    // Reset overrides SCE/DE/UPD on the same edge.
    tick();
    check("rst_q", 64'(q0), 64'hA5);
    check("rst_sco", 64'(sco0), 64'h1);
    check("rst_done", 64'(done0), 64'h0);
    check("rst_q_lsb", 64'(q1), 64'hA5);
    check("rst_sco_lsb", 64'(sco1), 64'h1);

    // Parallel load, then update.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
    tick();
`ifdef SCAN_SHADOW_EN
    check("load_q_shadow", 64'(q0), 64'hA5);
`else
    check("load_q", 64'(q0), 64'h3C);
`endif
    check("load_sco", 64'(sco0), 64'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check("upd_q", 64'(q0), 64'h3C);

    // Full 8-bit frame from A5; DE and UPD asserted throughout must be ignored.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, scd_v[i], 8'h00);
      check($sformatf("frame_sco%0d", i), 64'(sco0), 64'(sco_v[i]));
      check($sformatf("frame_sco_lsb%0d", i), 64'(sco1), 64'(sco_v[i]));
      tick();
      check($sformatf("frame_done%0d", i), 64'(done0), 64'(i == 7));
      check($sformatf("frame_done_lsb%0d", i), 64'(done1), 64'(i == 7));
`ifdef SCAN_SHADOW_EN
      check($sformatf("frame_q_hold%0d", i), 64'(q0), 64'hA5);
`endif
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check("frame_done_clear", 64'(done0), 64'h0);
    check("frame_core", 64'(q0), 64'hB2);
    check("frame_core_lsb", 64'(q1), 64'h4D);

    // 5 shifts, one idle edge aborting the frame, then a full 8-shift frame.
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, (i != 5), 1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      check($sformatf("abort_done%0d", i), 64'(done0), 64'(i == 13));
    end

    // Reset on the 4th shift restarts the count; DE stays asserted and is ignored.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      tick();
      check($sformatf("pre_rst_done%0d", i), 64'(done0), 64'h0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
    tick();
    check("mid_rst_q", 64'(q0), 64'hA5);
    check("mid_rst_done", 64'(done0), 64'h0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
      tick();
      check($sformatf("post_rst_done%0d", i), 64'(done0), 64'(i == 7));
    end
    check("post_rst_sco", 64'(sco0), 64'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check("post_rst_core", 64'(q0), 64'hFF);

    // Simultaneous UPD and DE: shadow takes the old core, core takes D.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check("pre_upd_q", 64'(q0), 64'h11);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22);
    tick();
`ifdef SCAN_SHADOW_EN
    check("upd_de_q", 64'(q0), 64'h11);
`else
    check("upd_de_q", 64'(q0), 64'h22);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check("upd_de_core", 64'(q0), 64'h22);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
    tick();
    check("hold_q", 64'(q0), 64'h22);
    check("hold_sco", 64'(sco0), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
